// File: rtl/fifo_buffer.sv
// fifo_buffer: synchronous single-clock FIFO with registered read data,
// registered full/empty flags and an occupancy count.
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// flags; without it both flags are tied to 0 and the port list is unchanged.
module fifo_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [AW:0]       r_count;
  logic              r_full;
  logic              r_empty;
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdValid;

  logic              w_pushOk;
  logic              w_popOk;
  logic [AW:0]       w_countNext;

  // Acceptance uses the registered flags from before the edge, so push+pop
  // while full only pops and push+pop while empty only pushes.
  assign w_pushOk = push & ~r_full;
  assign w_popOk  = pop  & ~r_empty;

  // Next occupancy: simultaneous accepted push and pop leave it unchanged.
  always_comb begin
    w_countNext = r_count;
    if (w_pushOk && !w_popOk) begin
      w_countNext = r_count + 1'b1;
    end else if (!w_pushOk && w_popOk) begin
      w_countNext = r_count - 1'b1;
    end
  end

  // Storage array is never reset; a reset simply discards it via the pointers.
  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_mem[r_wrPtr] <= wr_data;
    end
  end

  // Pointers, count, flags and read data; flags derive from the next count so
  // they always agree with count in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= w_popOk;
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_popOk) begin
        r_rdData <= r_mem[r_rdPtr];
        r_rdPtr  <= r_rdPtr + 1'b1;
      end
      r_count <= w_countNext;
      r_full  <= (w_countNext == FULL_CNT);
      r_empty <= (w_countNext == '0);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags: set on any rejected request, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push && r_full) begin
        r_overflow <= 1'b1;
      end
      if (pop && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign rd_data    = r_rdData;
  assign rd_valid   = r_rdValid;
  assign fifo_full  = r_full;
  assign fifo_empty = r_empty;
  assign count      = r_count;

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed self-checking bench for fifo_buffer (DEPTH=8,
// DATA_W=8). Expectations for overflow/underflow follow FIFO_ERR_FLAGS_EN.
module tb_fifo_buffer;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       push;
  logic [7:0] wr_data;
  logic       pop;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       fifo_full;
  logic       fifo_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  fifo_buffer #(.DATA_W(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wr_data   (wr_data),
    .pop       (pop),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests at the falling edge, return 1 ns after the rising edge.
  task automatic applyStimulus(input logic p, input logic [7:0] d, input logic q);
    @(negedge clk);
    push    = p;
    wr_data = d;
    pop     = q;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; wr_data = 8'h00;
    #12;
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b exp 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b exp 0", fifo_full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data got %h exp 00", rd_data); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_flags got %b%b exp 00", overflow, underflow); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      checks++; if (count !== 4'(i)) begin errors++; $display("[TB] FAIL fill_count[%0d] got %0d exp %0d", i, count, i); end
      checks++; if (fifo_empty !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty[%0d] got %b exp 0", i, fifo_empty); end
      checks++; if (fifo_full !== (i == 8)) begin errors++; $display("[TB] FAIL fill_full[%0d] got %b exp %b", i, fifo_full, (i == 8)); end
    end
  endtask

  task automatic test_overflow();
    applyStimulus(1'b1, 8'hAA, 1'b0);
    checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL ovf_count got %0d exp 8", count); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full got %b exp 1", fifo_full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_rd_valid got %b exp 0", rd_valid); end
    checks++; if (overflow !== ERR_EN) begin errors++; $display("[TB] FAIL ovf_flag got %b exp %b", overflow, ERR_EN); end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checks++; if (overflow !== ERR_EN) begin errors++; $display("[TB] FAIL ovf_sticky got %b exp %b", overflow, ERR_EN); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_valid[%0d] got %b exp 1", i, rd_valid); end
      checks++; if (rd_data !== 8'(i)) begin errors++; $display("[TB] FAIL drain_data[%0d] got %h exp %h", i, rd_data, 8'(i)); end
      checks++; if (count !== 4'(8 - i)) begin errors++; $display("[TB] FAIL drain_count[%0d] got %0d exp %0d", i, count, 8 - i); end
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 8'h08) begin errors++; $display("[TB] FAIL idle_hold got %h exp 08", rd_data); end
    checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL drained_flags got e%b f%b exp e1 f0", fifo_empty, fifo_full); end
  endtask

  task automatic test_underflow();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL udf_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 8'h08) begin errors++; $display("[TB] FAIL udf_hold got %h exp 08", rd_data); end
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL udf_count got %0d exp 0", count); end
    checks++; if (underflow !== ERR_EN) begin errors++; $display("[TB] FAIL udf_flag got %b exp %b", underflow, ERR_EN); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0);
    checks++; if (count !== 4'd4) begin errors++; $display("[TB] FAIL b2b_prefill got %0d exp 4", count); end
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 8'h14 + 8'(k), 1'b1);
      checks++; if (count !== 4'd4) begin errors++; $display("[TB] FAIL b2b_count[%0d] got %0d exp 4", k, count); end
      checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h10 + 8'(k)) begin errors++; $display("[TB] FAIL b2b_data[%0d] got v%b %h exp v1 %h", k, rd_valid, rd_data, 8'h10 + 8'(k)); end
    end
  endtask

  task automatic test_simultaneous_edges();
    // FIFO holds 0x24..0x27; top up to full with 0x30..0x33
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h30 + 8'(i), 1'b0);
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("[TB] FAIL topup_full got %b exp 1", fifo_full); end
    applyStimulus(1'b1, 8'h99, 1'b1);
    checks++; if (count !== 4'd7 || fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL pp_full got c%0d f%b exp c7 f0", count, fifo_full); end
    checks++; if (rd_data !== 8'h24) begin errors++; $display("[TB] FAIL pp_full_data got %h exp 24", rd_data); end
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checks++; if (count !== 4'd5 || rd_data !== 8'h26) begin errors++; $display("[TB] FAIL pre_reset got c%0d %h exp c5 26", count, rd_data); end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL midrst_state got c%0d e%b f%b exp c0 e1 f0", count, fifo_empty, fifo_full); end
    checks++; if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rd got v%b %h exp v0 00", rd_valid, rd_data); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL midrst_err got %b%b exp 00", overflow, underflow); end
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || count !== 4'd0) begin errors++; $display("[TB] FAIL postrst_pop got v%b %h c%0d exp v0 00 c0", rd_valid, rd_data, count); end
    checks++; if (underflow !== ERR_EN) begin errors++; $display("[TB] FAIL postrst_udf got %b exp %b", underflow, ERR_EN); end
    applyStimulus(1'b1, 8'h55, 1'b1);
    checks++; if (count !== 4'd1 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL pp_empty got c%0d v%b exp c1 v0", count, rd_valid); end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h55 || fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL pp_empty_read got v%b %h e%b exp v1 55 e1", rd_valid, rd_data, fifo_empty); end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_back_to_back();
    test_simultaneous_edges();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
FIFO_BUFFER -- requirements
Module: fifo_buffer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning width of each stored word.
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning number of entries; it must be a power of 2 and at least 2.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port push, input, 1 bit: write request.
REQ-006 The module SHALL have port wr_data, input, DATA_W bits: data written on an accepted push.
REQ-007 The module SHALL have port pop, input, 1 bit: read request.
REQ-008 The module SHALL have port rd_data, output, DATA_W bits: registered read data.
REQ-009 The module SHALL have port rd_valid, output, 1 bit: rd_data was updated by an accepted pop on the previous edge.
REQ-010 The module SHALL have port fifo_full, output, 1 bit: count equals DEPTH.
REQ-011 The module SHALL have port fifo_empty, output, 1 bit: count equals 0.
REQ-012 The module SHALL have port count, output, log2(DEPTH)+1 bits: current occupancy.
REQ-013 The module SHALL have port overflow, output, 1 bit: sticky flag for a push attempted while full.
REQ-014 The module SHALL have port underflow, output, 1 bit: sticky flag for a pop attempted while empty.

Function
REQ-015 A push SHALL be accepted only when fifo_full is 0 at the sampling edge; wr_data is stored at the write pointer, which then increments.
REQ-016 A pop SHALL be accepted only when fifo_empty is 0 at the sampling edge; the entry at the read pointer is registered into rd_data, the read pointer increments, and rd_valid is 1 for exactly the following cycle.
REQ-017 rd_data SHALL hold its last value when no pop is accepted; rd_valid SHALL be 0 in that cycle.
REQ-018 Pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without any gap cycle.
REQ-019 Acceptance SHALL be decided from the flags present before the edge: push+pop while full performs the pop only (count-1); push+pop while empty performs the push only (count+1); push+pop otherwise performs both (count unchanged).
REQ-020 fifo_full and fifo_empty SHALL be registered, consistent with count in the same cycle, and never both 1.
REQ-021 Rejected requests SHALL change no pointer, no memory entry, no count and no rd_data.
REQ-022 Data SHALL leave in strict first-in-first-out order across any number of wrap-arounds.

Reset
REQ-023 While rst_n is 0, regardless of clk: pointers=0, count=0, fifo_empty=1, fifo_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
REQ-024 Reset asserted mid-operation SHALL discard all stored data; memory contents need not be cleared.
REQ-025 The first edge after rst_n rises SHALL accept a push normally.

Configuration
REQ-026 Macro FIFO_ERR_FLAGS_EN SHALL control error logging. When defined, overflow sets on push while full, underflow sets on pop while empty, and both stay set until reset. When undefined, overflow and underflow are constant 0 and no error logic exists. The port list SHALL be identical in both builds.

Verification
REQ-027 DEPTH=8: reset, then 8 pushes of 0x01..0x08 -> fifo_full=1, count=8, fifo_empty=0.
REQ-028 The bench SHALL drain with 8 pops -> rd_data sequence 0x01..0x08, each with rd_valid=1 the following cycle, ending at fifo_empty=1 and count=0.
REQ-029 With full, push 0xAA -> no state change; with FIFO_ERR_FLAGS_EN, overflow=1 and stays 1; without it, overflow=0.
REQ-030 With empty, pop -> rd_valid=0, rd_data unchanged; with FIFO_ERR_FLAGS_EN, underflow=1.
REQ-031 Fill with 4 entries, hold push+pop for 20 cycles -> count stays 4 and output order is preserved across pointer wrap.
REQ-032 With count=5, pulse rst_n low between clock edges -> all outputs take their reset values immediately; the next pop is rejected.
